mem_arbiter: RTL

- Sequences the single byte-wide external RAM port and shares it between two requesters: instruction fetch (IF) and the memory stage (MEM).
- Converts 1/2/4-byte little-endian load/store requests into byte-serial RAM cycles.
- Sign- or zero-extends load data.
- Produces the done handshakes that the memory stage turns into its pipeline stall.

---
 rtl/mem_arbiter_if.sv | 61 ++++++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
// Requester and byte-RAM signals around mem_arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_read;
  logic              mem_write;
  logic              mem_signed;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_len;
  logic [31:0]       mem_w_data;
  logic [31:0]       mem_r_data;
  logic              mem_done;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport slave (
    input  if_req,
    input  if_addr,
    output if_data,
    output if_done,
    input  mem_read,
    input  mem_write,
    input  mem_signed,
    input  mem_addr,
    input  mem_len,
    input  mem_w_data,
    output mem_r_data,
    output mem_done,
    input  ram_din,
    output ram_dout,
    output ram_a,
    output ram_wr
  );

  modport master (
    output if_req,
    output if_addr,
    input  if_data,
    input  if_done,
    output mem_read,
    output mem_write,
    output mem_signed,
    output mem_addr,
    output mem_len,
    output mem_w_data,
    input  mem_r_data,
    input  mem_done,
    output ram_din,
    input  ram_dout,
    input  ram_a,
    input  ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: shares one byte-wide RAM port between fetch and the
// memory stage, serialising 1/2/4-byte little-endian accesses.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input logic          clk_in,
  input logic          rst_n_in,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_TAIL,
    WR,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]        cnt;
  logic [1:0]        n_m1;
  logic [1:0]        len_nm1;
  logic              grant_if;
  logic              sgn;
  logic [31:0]       wbuf;
  logic [23:0]       rbuf;
  logic [ADDR_W-1:0] ram_a_q;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_r_data_q;
  logic              if_done_q;
  logic              done_q;

  logic              req_mem;
  logic              last;
  logic              sbit;
  logic [31:0]       rfull;
  logic [31:0]       rext;

  assign req_mem = bus.mem_read | bus.mem_write;
  assign last    = (cnt == n_m1);

  always_comb begin
    len_nm1 = 2'd3;
    unique case (bus.mem_len)
      2'b00:   len_nm1 = 2'd0;
      2'b01:   len_nm1 = 2'd1;
      default: len_nm1 = 2'd3;
    endcase
  end

  // The last byte of any load arrives straight from ram_din in RD_TAIL,
  // so its top bit is the sign bit for every size.
  always_comb begin
    rfull = {bus.ram_din, rbuf};
    sbit  = sgn & bus.ram_din[7];
    rext  = rfull;
    unique case (n_m1)
      2'd0:    rext = {{24{sbit}}, rfull[31:24]};
      2'd1:    rext = {{16{sbit}}, rfull[31:16]};
      default: rext = rfull;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.mem_write) begin
          state_nxt = WR;
        end else if (bus.mem_read || bus.if_req) begin
          state_nxt = RD;
        end
      end
      RD: begin
        if (last) begin
          state_nxt = RD_TAIL;
        end
      end
      RD_TAIL: state_nxt = DONE;
      WR: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt          <= 2'd0;
      n_m1         <= 2'd0;
      grant_if     <= 1'b0;
      sgn          <= 1'b0;
      wbuf         <= 32'd0;
      rbuf         <= 24'd0;
      ram_a_q      <= '0;
      if_data_q    <= 32'd0;
      mem_r_data_q <= 32'd0;
      if_done_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= 2'd0;
          if (req_mem) begin
            grant_if <= 1'b0;
            n_m1     <= len_nm1;
            sgn      <= bus.mem_signed;
            wbuf     <= bus.mem_w_data;
            ram_a_q  <= bus.mem_addr;
          end else if (bus.if_req) begin
            grant_if <= 1'b1;
            n_m1     <= 2'd3;
            sgn      <= 1'b0;
            ram_a_q  <= bus.if_addr;
          end
        end
        RD: begin
          if (cnt != 2'd0) begin
            rbuf <= {bus.ram_din, rbuf[23:8]};
          end
          if (!last) begin
            cnt     <= cnt + 2'd1;
            ram_a_q <= ram_a_q + ADDR_W'(1);
          end
        end
        RD_TAIL: begin
          done_q <= 1'b1;
          if (grant_if) begin
            if_data_q <= rfull;
            if_done_q <= 1'b1;
          end else begin
            mem_r_data_q <= rext;
          end
        end
        WR: begin
          wbuf <= wbuf >> 8;
          if (last) begin
            done_q <= 1'b1;
          end else begin
            cnt     <= cnt + 2'd1;
            ram_a_q <= ram_a_q + ADDR_W'(1);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    bus.ram_wr     = (state == WR);
    bus.ram_dout   = (state == WR) ? wbuf[7:0] : 8'h00;
    bus.ram_a      = ram_a_q;
    bus.if_data    = if_data_q;
    bus.if_done    = if_done_q;
    bus.mem_r_data = mem_r_data_q;
    bus.mem_done   = (done_q && !grant_if) ||
                     ((state == IDLE) && !req_mem);
  end

endmodule
